rs_station_param: RTL and testbench

//  Parametrised Tomasulo reservation station: holds up to ENTRIES waiting ops, captures operands off the CDB,
//  and issues one ready op per cycle to its functional unit. Sits between dispatch (ROB tag alloc) and one FU.

---
 rtl/rs_station_param.sv | 185 ++++++++++++++++++
 tb/tb_rs_station_param.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_station_param.sv
// Tomasulo reservation station: holds waiting ops, snoops the CDB and issues one ready op per cycle.
// Define RS_AGE_SELECT_EN to issue oldest-ready first; otherwise the lowest-index ready entry issues.
module rs_station_param #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TAG_W   = 3,
    parameter int unsigned OP_W    = 5
) (
    input  logic                      clk1,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    input  logic [OP_W-1:0]           alloc_func,
    input  logic [TAG_W-1:0]          alloc_dest,
    input  logic [DATA_W-1:0]         alloc_vj,
    input  logic [DATA_W-1:0]         alloc_vk,
    input  logic [TAG_W-1:0]          alloc_qj,
    input  logic [TAG_W-1:0]          alloc_qk,
    input  logic                      alloc_qj_busy,
    input  logic                      alloc_qk_busy,
    input  logic                      cdb_valid,
    input  logic [TAG_W-1:0]          cdb_tag,
    input  logic [DATA_W-1:0]         cdb_data,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [OP_W-1:0]           issue_func,
    output logic [DATA_W-1:0]         issue_vj,
    output logic [DATA_W-1:0]         issue_vk,
    output logic [TAG_W-1:0]          issue_dest,
    output logic [$clog2(ENTRIES):0]  count
);

    localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int unsigned CNT_W = $clog2(ENTRIES) + 1;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] qj_busy_q;
    logic [ENTRIES-1:0] qk_busy_q;
    logic [OP_W-1:0]    func_q [ENTRIES];
    logic [TAG_W-1:0]   dest_q [ENTRIES];
    logic [DATA_W-1:0]  vj_q   [ENTRIES];
    logic [DATA_W-1:0]  vk_q   [ENTRIES];
    logic [TAG_W-1:0]   qj_q   [ENTRIES];
    logic [TAG_W-1:0]   qk_q   [ENTRIES];

    logic [ENTRIES-1:0] ready;
    logic [ENTRIES-1:0] cand;
    logic [ENTRIES-1:0] wake_j;
    logic [ENTRIES-1:0] wake_k;
    logic [IDX_W-1:0]   alloc_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic               alloc_fire;
    logic               issue_fire;
    logic               fwd_j;
    logic               fwd_k;

    // Readiness and CDB tag match, all entries in parallel
    always_comb begin
        ready  = valid_q & ~qj_busy_q & ~qk_busy_q;
        wake_j = '0;
        wake_k = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            wake_j[i] = cdb_valid && valid_q[i] && qj_busy_q[i] && (qj_q[i] == cdb_tag);
            wake_k[i] = cdb_valid && valid_q[i] && qk_busy_q[i] && (qk_q[i] == cdb_tag);
        end
    end

    // Lowest-index free slot; a slot freed by this cycle's issue is not visible yet
    always_comb begin
        alloc_idx = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_idx = IDX_W'(i);
        end
    end

    assign alloc_ready = ~&valid_q;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign fwd_j       = cdb_valid && alloc_qj_busy && (alloc_qj == cdb_tag);
    assign fwd_k       = cdb_valid && alloc_qk_busy && (alloc_qk == cdb_tag);

`ifdef RS_AGE_SELECT_EN
    // older_q[a][b] set means entry a was allocated before entry b
    logic [ENTRIES-1:0] older_q [ENTRIES];

    always_comb begin
        cand = ready;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            for (int j = 0; j < int'(ENTRIES); j++) begin
                if (ready[j] && older_q[j][i]) cand[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            older_q <= '{default: '0};
        end else if (alloc_fire && !flush) begin
            for (int j = 0; j < int'(ENTRIES); j++) begin
                older_q[alloc_idx][j] <= 1'b0;
                older_q[j][alloc_idx] <= valid_q[j];
            end
        end
    end

    always_comb begin
        sel_idx = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (cand[i]) sel_idx = IDX_W'(i);
        end
    end
`else
    // A stalled presentation is held so the FU sees a stable op
    logic             hold_vld_q;
    logic [IDX_W-1:0] hold_idx_q;

    assign cand = ready;

    always_comb begin
        sel_idx = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (cand[i]) sel_idx = IDX_W'(i);
        end
        if (hold_vld_q) sel_idx = hold_idx_q;
    end

    always_ff @(posedge clk1) begin
        if (rst || flush) begin
            hold_vld_q <= 1'b0;
        end else begin
            hold_vld_q <= issue_valid && !issue_ready;
            hold_idx_q <= sel_idx;
        end
    end
`endif

    assign issue_valid = |ready;
    assign issue_fire  = issue_valid && issue_ready;
    assign issue_func  = func_q[sel_idx];
    assign issue_vj    = vj_q[sel_idx];
    assign issue_vk    = vk_q[sel_idx];
    assign issue_dest  = dest_q[sel_idx];

    always_comb begin
        count = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            count = count + CNT_W'(valid_q[i]);
        end
    end

    // Occupancy and pending-operand flags
    always_ff @(posedge clk1) begin
        if (rst || flush) begin
            valid_q   <= '0;
            qj_busy_q <= '0;
            qk_busy_q <= '0;
        end else begin
            qj_busy_q <= qj_busy_q & ~wake_j;
            qk_busy_q <= qk_busy_q & ~wake_k;
            if (issue_fire) valid_q[sel_idx] <= 1'b0;
            if (alloc_fire) begin
                valid_q[alloc_idx]   <= 1'b1;
                qj_busy_q[alloc_idx] <= alloc_qj_busy && !fwd_j;
                qk_busy_q[alloc_idx] <= alloc_qk_busy && !fwd_k;
            end
        end
    end

    // Payload; contents of invalid entries are don't-care
    always_ff @(posedge clk1) begin
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (wake_j[i]) vj_q[i] <= cdb_data;
            if (wake_k[i]) vk_q[i] <= cdb_data;
        end
        if (alloc_fire) begin
            func_q[alloc_idx] <= alloc_func;
            dest_q[alloc_idx] <= alloc_dest;
            qj_q[alloc_idx]   <= alloc_qj;
            qk_q[alloc_idx]   <= alloc_qk;
            vj_q[alloc_idx]   <= fwd_j ? cdb_data : alloc_vj;
            vk_q[alloc_idx]   <= fwd_k ? cdb_data : alloc_vk;
        end
    end

endmodule

// File: tb/tb_rs_station_param.sv
// Bench for rs_station_param: directed vector table plus random traffic against a slot/sequence model.
module tb_rs_station_param;

    localparam int unsigned ENTRIES = 4;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned TAG_W   = 3;
    localparam int unsigned OP_W    = 5;
    localparam int unsigned CNT_W   = $clog2(ENTRIES) + 1;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic              rst, flush, alloc_valid, alloc_ready, alloc_qj_busy, alloc_qk_busy;
    logic [OP_W-1:0]   alloc_func, issue_func;
    logic [TAG_W-1:0]  alloc_dest, alloc_qj, alloc_qk, cdb_tag, issue_dest;
    logic [DATA_W-1:0] alloc_vj, alloc_vk, cdb_data, issue_vj, issue_vk;
    logic              cdb_valid, issue_valid, issue_ready;
    logic [CNT_W-1:0]  count;

    rs_station_param #(.ENTRIES(ENTRIES), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
        .clk1(clk1), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_func(alloc_func),
        .alloc_dest(alloc_dest), .alloc_vj(alloc_vj), .alloc_vk(alloc_vk),
        .alloc_qj(alloc_qj), .alloc_qk(alloc_qk),
        .alloc_qj_busy(alloc_qj_busy), .alloc_qk_busy(alloc_qk_busy),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_func(issue_func),
        .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_dest(issue_dest), .count(count)
    );

    typedef struct {
        bit rst, flush, av;
        logic [OP_W-1:0] func;
        logic [TAG_W-1:0] dest, qj, qk, ctag;
        logic [DATA_W-1:0] vj, vk, cdata;
        bit jb, kb, cv, ir;
    } in_t;

    typedef struct {
        bit ar;
        int cnt;
        bit iv;
        logic [OP_W-1:0] func;
        logic [DATA_W-1:0] vj, vk;
        logic [TAG_W-1:0] dest;
    } exp_t;

    typedef struct {
        in_t  stim;
        exp_t want;
    } row_t;

    typedef struct {
        bit v, jb, kb;
        logic [OP_W-1:0] func;
        logic [TAG_W-1:0] dest, qj, qk;
        logic [DATA_W-1:0] vj, vk;
        int unsigned seq;
    } ment_t;

    ment_t       m [ENTRIES];
    bit          m_hold;
    int          m_hold_slot;
    int unsigned m_seq;
    row_t        rows [$];
    int          nvec, nmis;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit m_rdy(int i);
        return m[i].v && !m[i].jb && !m[i].kb;
    endfunction

    // Expected outputs from the model's current contents
    function automatic void m_view(output bit ar, output int cnt, output bit iv, output int sel);
        ar = 1'b0; cnt = 0; sel = -1;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (!m[i].v) ar = 1'b1;
            else cnt++;
        end
`ifdef RS_AGE_SELECT_EN
        for (int i = 0; i < int'(ENTRIES); i++)
            if (m_rdy(i) && (sel < 0 || m[i].seq < m[sel].seq)) sel = i;
`else
        if (m_hold) sel = m_hold_slot;
        else
            for (int i = 0; i < int'(ENTRIES); i++)
                if (m_rdy(i) && sel < 0) sel = i;
`endif
        iv = (sel >= 0);
    endfunction

    function automatic void m_update(in_t s);
        bit ar, iv;
        int cnt, sel, free;
        if (s.rst || s.flush) begin
            for (int i = 0; i < int'(ENTRIES); i++) m[i].v = 1'b0;
            m_hold = 1'b0;
            return;
        end
        m_view(ar, cnt, iv, sel);
        free = -1;
        for (int i = 0; i < int'(ENTRIES); i++) if (!m[i].v && free < 0) free = i;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (m[i].v && s.cv && m[i].jb && m[i].qj == s.ctag) begin m[i].vj = s.cdata; m[i].jb = 1'b0; end
            if (m[i].v && s.cv && m[i].kb && m[i].qk == s.ctag) begin m[i].vk = s.cdata; m[i].kb = 1'b0; end
        end
        if (iv && s.ir) m[sel].v = 1'b0;
        m_hold      = iv && !s.ir;
        m_hold_slot = sel;
        if (s.av && ar) begin
            m[free].v    = 1'b1;
            m[free].func = s.func;
            m[free].dest = s.dest;
            m[free].qj   = s.qj;
            m[free].qk   = s.qk;
            m[free].jb   = s.jb && !(s.cv && s.ctag == s.qj);
            m[free].kb   = s.kb && !(s.cv && s.ctag == s.qk);
            m[free].vj   = (s.jb && s.cv && s.ctag == s.qj) ? s.cdata : s.vj;
            m[free].vk   = (s.kb && s.cv && s.ctag == s.qk) ? s.cdata : s.vk;
            m[free].seq  = m_seq++;
        end
    endfunction

    task automatic step(input in_t s, input bit has_want, input exp_t e, input int id);
        bit ar, iv;
        int cnt, sel;
        rst = s.rst; flush = s.flush; alloc_valid = s.av; alloc_func = s.func;
        alloc_dest = s.dest; alloc_vj = s.vj; alloc_vk = s.vk; alloc_qj = s.qj; alloc_qk = s.qk;
        alloc_qj_busy = s.jb; alloc_qk_busy = s.kb; cdb_valid = s.cv; cdb_tag = s.ctag;
        cdb_data = s.cdata; issue_ready = s.ir;
        @(negedge clk1);
        m_view(ar, cnt, iv, sel);
        cmp("model alloc_ready", 32'(alloc_ready), 32'(ar));
        cmp("model count", 32'(count), 32'(cnt));
        cmp("model issue_valid", 32'(issue_valid), 32'(iv));
        if (iv) begin
            cmp("model issue_func", 32'(issue_func), 32'(m[sel].func));
            cmp("model issue_vj", 32'(issue_vj), 32'(m[sel].vj));
            cmp("model issue_vk", 32'(issue_vk), 32'(m[sel].vk));
            cmp("model issue_dest", 32'(issue_dest), 32'(m[sel].dest));
        end
        if (has_want) begin
            cmp($sformatf("row%0d alloc_ready", id), 32'(alloc_ready), 32'(e.ar));
            cmp($sformatf("row%0d count", id), 32'(count), 32'(e.cnt));
            cmp($sformatf("row%0d issue_valid", id), 32'(issue_valid), 32'(e.iv));
            if (e.iv) begin
                cmp($sformatf("row%0d issue_func", id), 32'(issue_func), 32'(e.func));
                cmp($sformatf("row%0d issue_vj", id), 32'(issue_vj), 32'(e.vj));
                cmp($sformatf("row%0d issue_vk", id), 32'(issue_vk), 32'(e.vk));
                cmp($sformatf("row%0d issue_dest", id), 32'(issue_dest), 32'(e.dest));
            end
        end
        m_update(s);
        @(posedge clk1);
        #1;
    endtask

    function automatic in_t idle(bit ir);
        in_t s = '{default: '0};
        s.ir = ir;
        return s;
    endfunction

    function automatic in_t al(logic [OP_W-1:0] f, logic [TAG_W-1:0] d, logic [DATA_W-1:0] vj,
                               logic [DATA_W-1:0] vk, logic [TAG_W-1:0] qj, bit jb,
                               logic [TAG_W-1:0] qk, bit kb, bit ir);
        in_t s = idle(ir);
        s.av = 1'b1; s.func = f; s.dest = d; s.vj = vj; s.vk = vk;
        s.qj = qj; s.jb = jb; s.qk = qk; s.kb = kb;
        return s;
    endfunction

    function automatic in_t bc(in_t s0, logic [TAG_W-1:0] tag, logic [DATA_W-1:0] data);
        in_t s = s0;
        s.cv = 1'b1; s.ctag = tag; s.cdata = data;
        return s;
    endfunction

    function automatic in_t fl(in_t s0);
        in_t s = s0;
        s.flush = 1'b1;
        return s;
    endfunction

    function automatic exp_t ex(int cnt, bit iv, logic [OP_W-1:0] f, logic [DATA_W-1:0] vj,
                                logic [DATA_W-1:0] vk, logic [TAG_W-1:0] d);
        exp_t e;
        e.ar = (cnt < int'(ENTRIES)); e.cnt = cnt; e.iv = iv;
        e.func = f; e.vj = vj; e.vk = vk; e.dest = d;
        return e;
    endfunction

    function automatic void add(in_t s, exp_t e);
        row_t r;
        r.stim = s; r.want = e;
        rows.push_back(r);
    endfunction

    function automatic in_t rnd();
        in_t s;
        s.rst   = ($urandom_range(0, 299) == 0);
        s.flush = ($urandom_range(0, 63) == 0);
        s.av    = ($urandom_range(0, 9) < 6);
        s.func  = OP_W'($urandom);
        s.dest  = TAG_W'($urandom);
        s.vj    = DATA_W'($urandom);
        s.vk    = DATA_W'($urandom);
        s.qj    = TAG_W'($urandom);
        s.qk    = TAG_W'($urandom);
        s.jb    = 1'($urandom_range(0, 1));
        s.kb    = 1'($urandom_range(0, 1));
        s.cv    = ($urandom_range(0, 9) < 4);
        s.ctag  = TAG_W'($urandom);
        s.cdata = DATA_W'($urandom);
        s.ir    = ($urandom_range(0, 9) < 6);
        return s;
    endfunction

    initial begin
        exp_t none = '{default: '0};
        exp_t first, second;
        nvec = 0; nmis = 0; m_seq = 0; m_hold = 1'b0; m_hold_slot = 0;
        for (int i = 0; i < int'(ENTRIES); i++) m[i] = '{default: '0};
        rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_func = '0; alloc_dest = '0;
        alloc_vj = '0; alloc_vk = '0; alloc_qj = '0; alloc_qk = '0; alloc_qj_busy = 1'b0;
        alloc_qk_busy = 1'b0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; issue_ready = 1'b0;
        @(posedge clk1);
        #1;

        // Ready op issues the cycle after allocation
        add(al(5'd3, 3'd2, 16'd5, 16'd7, 3'd0, 0, 3'd0, 0, 1), ex(0, 0, 0, 0, 0, 0));
        add(idle(1), ex(1, 1, 5'd3, 16'd5, 16'd7, 3'd2));
        add(idle(1), ex(0, 0, 0, 0, 0, 0));
        // j waits for tag 4
        add(al(5'd1, 3'd3, 16'd0, 16'd9, 3'd4, 1, 3'd0, 0, 1), ex(0, 0, 0, 0, 0, 0));
        add(idle(1), ex(1, 0, 0, 0, 0, 0));
        add(bc(idle(1), 3'd4, 16'h00AA), ex(1, 0, 0, 0, 0, 0));
        add(idle(1), ex(1, 1, 5'd1, 16'h00AA, 16'd9, 3'd3));
        add(idle(1), ex(0, 0, 0, 0, 0, 0));
        // Broadcast in the allocation cycle is forwarded
        add(bc(al(5'd2, 3'd5, 16'd0, 16'd1, 3'd6, 1, 3'd0, 0, 1), 3'd6, 16'h1234), ex(0, 0, 0, 0, 0, 0));
        add(idle(1), ex(1, 1, 5'd2, 16'h1234, 16'd1, 3'd5));
        add(idle(1), ex(0, 0, 0, 0, 0, 0));
        // j and k wake together; stalled issue stays put
        add(al(5'd4, 3'd6, 16'd0, 16'd0, 3'd2, 1, 3'd2, 1, 0), ex(0, 0, 0, 0, 0, 0));
        add(bc(idle(0), 3'd2, 16'hBEEF), ex(1, 0, 0, 0, 0, 0));
        add(idle(0), ex(1, 1, 5'd4, 16'hBEEF, 16'hBEEF, 3'd6));
        add(idle(1), ex(1, 1, 5'd4, 16'hBEEF, 16'hBEEF, 3'd6));
        add(idle(1), ex(0, 0, 0, 0, 0, 0));
        // Non-matching tag ignored
        add(al(5'd7, 3'd1, 16'd0, 16'd2, 3'd3, 1, 3'd0, 0, 1), ex(0, 0, 0, 0, 0, 0));
        add(bc(idle(1), 3'd7, 16'h5555), ex(1, 0, 0, 0, 0, 0));
        add(bc(idle(1), 3'd3, 16'h0033), ex(1, 0, 0, 0, 0, 0));
        add(idle(1), ex(1, 1, 5'd7, 16'h0033, 16'd2, 3'd1));
        add(idle(1), ex(0, 0, 0, 0, 0, 0));

        // Older entry at a higher index: age vs index ordering
`ifdef RS_AGE_SELECT_EN
        first  = ex(2, 1, 5'd2, 16'h0101, 16'h0022, 3'd2);
        second = ex(1, 1, 5'd3, 16'h0101, 16'h0033, 3'd3);
`else
        first  = ex(2, 1, 5'd3, 16'h0101, 16'h0033, 3'd3);
        second = ex(1, 1, 5'd2, 16'h0101, 16'h0022, 3'd2);
`endif
        add(al(5'd1, 3'd1, 16'h0011, 16'h0012, 3'd0, 0, 3'd0, 0, 0), ex(0, 0, 0, 0, 0, 0));
        add(al(5'd2, 3'd2, 16'd0, 16'h0022, 3'd1, 1, 3'd0, 0, 0), ex(1, 1, 5'd1, 16'h0011, 16'h0012, 3'd1));
        add(idle(1), ex(2, 1, 5'd1, 16'h0011, 16'h0012, 3'd1));
        add(al(5'd3, 3'd3, 16'd0, 16'h0033, 3'd1, 1, 3'd0, 0, 0), ex(1, 0, 0, 0, 0, 0));
        add(bc(idle(0), 3'd1, 16'h0101), ex(2, 0, 0, 0, 0, 0));
        add(idle(1), first);
        add(idle(1), second);
        add(idle(0), ex(0, 0, 0, 0, 0, 0));

        // Fill, overflow attempt, free one slot, then flush beats alloc
        for (int i = 0; i < int'(ENTRIES); i++)
            add(al(OP_W'(i), TAG_W'(i), 16'd0, DATA_W'(16'h0100 + i), 3'd7, 1, 3'd0, 0, 0),
                ex(i, 0, 0, 0, 0, 0));
        add(al(5'd9, 3'd5, 16'd9, 16'd9, 3'd0, 0, 3'd0, 0, 0), ex(ENTRIES, 0, 0, 0, 0, 0));
        add(bc(idle(0), 3'd7, 16'h0777), ex(ENTRIES, 0, 0, 0, 0, 0));
        add(al(5'd9, 3'd5, 16'd9, 16'd9, 3'd0, 0, 3'd0, 0, 1), ex(ENTRIES, 1, 5'd0, 16'h0777, 16'h0100, 3'd0));
        add(idle(0), ex(ENTRIES - 1, 1, 5'd1, 16'h0777, 16'h0101, 3'd1));
        add(fl(al(5'd9, 3'd5, 16'd9, 16'd9, 3'd0, 0, 3'd0, 0, 0)), ex(ENTRIES - 1, 1, 5'd1, 16'h0777, 16'h0101, 3'd1));
        add(idle(0), ex(0, 0, 0, 0, 0, 0));
        add(idle(1), ex(0, 0, 0, 0, 0, 0));

        for (int k = 0; k < rows.size(); k++) step(rows[k].stim, 1'b1, rows[k].want, k);
        for (int k = 0; k < 3000; k++) step(rnd(), 1'b0, none, k);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
